count_time_hms: RTL and testbench

- Parametrised successor to the alarm clock's HH:MM time counter.
- Adds BCD seconds, a prescaler that derives the 1 Hz tick from the system clock, 12/24-hour display mode, load range validation, and event pulses (minute, day wrap).
- Sits between the clock/prescaler domain and the display/alarm-compare logic.
- Its outputs feed the 7-segment driver and the alarm comparator.

---
 rtl/count_time_hms_pkg.sv | 68 ++++++
 rtl/count_time_hms_digit_cnt.sv | 26 ++
 rtl/count_time_hms.sv | 123 ++++++++++++
 tb/tb_count_time_hms.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_time_hms_pkg.sv
// Shared digit widths, limits and BCD helpers for the HH:MM:SS counter.
// Hours are kept internally in 24-hour BCD; conversions happen only at load and display.
package time_pkg;

  localparam int U_SEC_W  = 4;
  localparam int Z_SEC_W  = 3;
  localparam int U_MIN_W  = 4;
  localparam int Z_MIN_W  = 3;
  localparam int U_HOUR_W = 4;
  localparam int Z_HOUR_W = 2;

  localparam int UNIT_MAX = 9;
  localparam int TENS_MAX = 5;
  localparam int HOUR_MAX = 23;

  function automatic logic [4:0] bcd_to_bin(input logic [1:0] z, input logic [3:0] u);
    return ({3'b000, z} * 5'd10) + {1'b0, u};
  endfunction

  // Returns {tens[1:0], units[3:0]}; input range 0-29.
  function automatic logic [5:0] bin_to_bcd(input logic [4:0] b);
    if (b >= 5'd20)      return {2'd2, 4'(b - 5'd20)};
    else if (b >= 5'd10) return {2'd1, 4'(b - 5'd10)};
    else                 return {2'd0, b[3:0]};
  endfunction

  function automatic logic bcd_valid_time(
    input logic       mode_12h,
    input logic [3:0] u_sec,
    input logic [2:0] z_sec,
    input logic [3:0] u_min,
    input logic [2:0] z_min,
    input logic [3:0] u_hour,
    input logic [1:0] z_hour
  );
    logic digits_ok;
    logic hour_ok;
    digits_ok = (u_sec <= 4'(UNIT_MAX)) && (z_sec <= 3'(TENS_MAX)) &&
                (u_min <= 4'(UNIT_MAX)) && (z_min <= 3'(TENS_MAX)) &&
                (u_hour <= 4'(UNIT_MAX));
    if (mode_12h)
      hour_ok = ((z_hour == 2'd0) && (u_hour != 4'd0)) ||
                ((z_hour == 2'd1) && (u_hour <= 4'd2));
    else
      hour_ok = bcd_to_bin(z_hour, u_hour) <= 5'(HOUR_MAX);
    return digits_ok && hour_ok;
  endfunction

  // 24-hour BCD -> {pm, z_hour, u_hour} in 12-hour display form.
  function automatic logic [6:0] to_12h(input logic [1:0] z_hour, input logic [3:0] u_hour);
    logic [4:0] b;
    b = bcd_to_bin(z_hour, u_hour);
    if (b == 5'd0)       return {1'b0, bin_to_bcd(5'd12)};
    else if (b < 5'd12)  return {1'b0, bin_to_bcd(b)};
    else if (b == 5'd12) return {1'b1, bin_to_bcd(5'd12)};
    else                 return {1'b1, bin_to_bcd(b - 5'd12)};
  endfunction

  // 12-hour BCD plus PM flag -> 24-hour {z_hour, u_hour}.
  function automatic logic [5:0] to_24h(input logic [1:0] z_hour, input logic [3:0] u_hour,
                                        input logic pm);
    logic [4:0] b;
    b = bcd_to_bin(z_hour, u_hour);
    if (b == 5'd12) return pm ? bin_to_bcd(5'd12) : 6'd0;
    else            return pm ? bin_to_bcd(b + 5'd12) : bin_to_bcd(b);
  endfunction

endpackage

// File: rtl/count_time_hms_digit_cnt.sv
// One BCD digit counting 0..MAX; carry_out flags the wrap on an increment.
module time_digit_cnt #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry_out
);

  assign carry_out = inc && (q == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= (q == W'(MAX)) ? '0 : q + W'(1);
  end

endmodule

// File: rtl/count_time_hms.sv
// HH:MM:SS BCD time counter with 1 Hz prescaler, 12/24-hour display and validated load.
// State is always 24-hour; the 12-hour view is derived combinationally.
module count_time_hms
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic                mode_12h,
  input  logic [U_SEC_W-1:0]  u_sec_in,
  input  logic [Z_SEC_W-1:0]  z_sec_in,
  input  logic [U_MIN_W-1:0]  u_min_in,
  input  logic [Z_MIN_W-1:0]  z_min_in,
  input  logic [U_HOUR_W-1:0] u_hour_in,
  input  logic [Z_HOUR_W-1:0] z_hour_in,
  input  logic                pm_in,
  output logic [U_SEC_W-1:0]  u_sec_out,
  output logic [Z_SEC_W-1:0]  z_sec_out,
  output logic [U_MIN_W-1:0]  u_min_out,
  output logic [Z_MIN_W-1:0]  z_min_out,
  output logic [U_HOUR_W-1:0] u_hour_out,
  output logic [Z_HOUR_W-1:0] z_hour_out,
  output logic                pm_out,
  output logic                min_tick,
  output logic                day_wrap,
  output logic                load_err
);

  localparam int PW = (TICK_DIV <= 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic                  load_ok, tick, tick_eff;
  logic                  su_c, sz_c, mu_c, mz_c;
  logic [U_HOUR_W-1:0]   u_hh;
  logic [Z_HOUR_W-1:0]   z_hh;
  logic [5:0]            hour_ld;
  logic [6:0]            disp12;
  logic                  at_23;

  assign load_ok  = load && bcd_valid_time(mode_12h, u_sec_in, z_sec_in, u_min_in, z_min_in,
                                           u_hour_in, z_hour_in);
  assign tick     = en && (presc == PRESC_LAST);
  assign tick_eff = tick && !load_ok;
  assign hour_ld  = mode_12h ? to_24h(z_hour_in, u_hour_in, pm_in) : {z_hour_in, u_hour_in};
  assign at_23    = (z_hh == 2'd2) && (u_hh == 4'd3);

  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (load_ok || tick)
      presc <= '0;
    else if (en)
      presc <= presc + PW'(1);
  end

  time_digit_cnt #(.MAX(UNIT_MAX), .W(U_SEC_W)) u_sec_cnt (
    .clk(clk), .rst(rst), .inc(tick_eff), .load(load_ok), .load_val(u_sec_in),
    .q(u_sec_out), .carry_out(su_c)
  );
  time_digit_cnt #(.MAX(TENS_MAX), .W(Z_SEC_W)) z_sec_cnt (
    .clk(clk), .rst(rst), .inc(su_c), .load(load_ok), .load_val(z_sec_in),
    .q(z_sec_out), .carry_out(sz_c)
  );
  time_digit_cnt #(.MAX(UNIT_MAX), .W(U_MIN_W)) u_min_cnt (
    .clk(clk), .rst(rst), .inc(sz_c), .load(load_ok), .load_val(u_min_in),
    .q(u_min_out), .carry_out(mu_c)
  );
  time_digit_cnt #(.MAX(TENS_MAX), .W(Z_MIN_W)) z_min_cnt (
    .clk(clk), .rst(rst), .inc(mu_c), .load(load_ok), .load_val(z_min_in),
    .q(z_min_out), .carry_out(mz_c)
  );

  // Hours wrap at 23 rather than at a digit boundary, so both digits are handled together.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_hh <= '0;
      u_hh <= '0;
    end else if (load_ok) begin
      z_hh <= hour_ld[5:4];
      u_hh <= hour_ld[3:0];
    end else if (mz_c) begin
      if (at_23) begin
        z_hh <= '0;
        u_hh <= '0;
      end else if (u_hh == 4'(UNIT_MAX)) begin
        z_hh <= z_hh + 2'd1;
        u_hh <= '0;
      end else begin
        u_hh <= u_hh + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      min_tick <= sz_c;
      day_wrap <= mz_c && at_23;
      load_err <= load && !load_ok;
    end
  end

  assign disp12 = to_12h(z_hh, u_hh);

  always_comb begin
    pm_out     = 1'b0;
    z_hour_out = z_hh;
    u_hour_out = u_hh;
    if (mode_12h) begin
      pm_out     = disp12[6];
      z_hour_out = disp12[5:4];
      u_hour_out = disp12[3:0];
    end
  end

endmodule

// File: tb/tb_count_time_hms.sv
// Directed bench for count_time_hms: one instance with TICK_DIV=1, one with TICK_DIV=4.
// Observed vectors are {pm, hh, mm, ss (BCD), min_tick, day_wrap, load_err}.
module tb_count_time_hms;

  logic       clk = 1'b0;
  logic       rst, en, load, mode_12h, pm_in;
  logic [3:0] u_sec_in, u_min_in, u_hour_in;
  logic [2:0] z_sec_in, z_min_in;
  logic [1:0] z_hour_in;

  logic [3:0] u_sec1, u_min1, u_hour1, u_sec4, u_min4, u_hour4;
  logic [2:0] z_sec1, z_min1, z_sec4, z_min4;
  logic [1:0] z_hour1, z_hour4;
  logic       pm1, mt1, dw1, le1, pm4, mt4, dw4, le4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  count_time_hms #(.TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode_12h(mode_12h),
    .u_sec_in(u_sec_in), .z_sec_in(z_sec_in), .u_min_in(u_min_in), .z_min_in(z_min_in),
    .u_hour_in(u_hour_in), .z_hour_in(z_hour_in), .pm_in(pm_in),
    .u_sec_out(u_sec1), .z_sec_out(z_sec1), .u_min_out(u_min1), .z_min_out(z_min1),
    .u_hour_out(u_hour1), .z_hour_out(z_hour1), .pm_out(pm1),
    .min_tick(mt1), .day_wrap(dw1), .load_err(le1)
  );

  count_time_hms #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode_12h(mode_12h),
    .u_sec_in(u_sec_in), .z_sec_in(z_sec_in), .u_min_in(u_min_in), .z_min_in(z_min_in),
    .u_hour_in(u_hour_in), .z_hour_in(z_hour_in), .pm_in(pm_in),
    .u_sec_out(u_sec4), .z_sec_out(z_sec4), .u_min_out(u_min4), .z_min_out(z_min4),
    .u_hour_out(u_hour4), .z_hour_out(z_hour4), .pm_out(pm4),
    .min_tick(mt4), .day_wrap(dw4), .load_err(le4)
  );

  wire [23:0] obs1 = {pm1, z_hour1, u_hour1, z_min1, u_min1, z_sec1, u_sec1, mt1, dw1, le1};
  wire [23:0] obs4 = {pm4, z_hour4, u_hour4, z_min4, u_min4, z_sec4, u_sec4, mt4, dw4, le4};

  function automatic logic [23:0] exp_v(input int h, input int m, input int s, input logic pm,
                                        input logic mt, input logic dw, input logic le);
    return {pm, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
            mt, dw, le};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int h, input int m, input int s, input logic pm);
    z_hour_in = 2'(h / 10);
    u_hour_in = 4'(h % 10);
    z_min_in  = 3'(m / 10);
    u_min_in  = 4'(m % 10);
    z_sec_in  = 3'(s / 10);
    u_sec_in  = 4'(s % 10);
    pm_in     = pm;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; mode_12h = 1'b0;
    set_load(0, 0, 0, 1'b0);
    step();
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL reset_24h: got %h, expected %h", obs1, exp_v(0, 0, 0, 0, 0, 0, 0));
    end
    mode_12h = 1'b1;
    #1;
    compared++;
    if (obs1 !== exp_v(12, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL reset_12h: got %h, expected %h", obs1, exp_v(12, 0, 0, 0, 0, 0, 0));
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_count();
    rst = 1'b0; en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      compared++;
      if (obs1 !== exp_v(0, i / 60, i % 60, 0, i == 60, 0, 0)) begin
        mismatched++;
        $display("[TB] FAIL count_%0d: got %h, expected %h", i, obs1,
                 exp_v(0, i / 60, i % 60, 0, i == 60, 0, 0));
      end
    end
  endtask

  task automatic test_day_wrap();
    set_load(23, 59, 58, 1'b0);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(23, 59, 58, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL wrap_load: got %h, expected %h", obs1, exp_v(23, 59, 58, 0, 0, 0, 0));
    end
    step();
    compared++;
    if (obs1 !== exp_v(23, 59, 59, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL wrap_59: got %h, expected %h", obs1, exp_v(23, 59, 59, 0, 0, 0, 0));
    end
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 0, 0, 1, 1, 0)) begin
      mismatched++;
      $display("[TB] FAIL wrap_00: got %h, expected %h", obs1, exp_v(0, 0, 0, 0, 1, 1, 0));
    end
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 1, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL wrap_after: got %h, expected %h", obs1, exp_v(0, 0, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_rejected();
    set_load(24, 0, 0, 1'b0);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(0, 0, 2, 0, 0, 0, 1)) begin
      mismatched++;
      $display("[TB] FAIL rej_hour24: got %h, expected %h", obs1, exp_v(0, 0, 2, 0, 0, 0, 1));
    end
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 3, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL rej_clear: got %h, expected %h", obs1, exp_v(0, 0, 3, 0, 0, 0, 0));
    end
    set_load(10, 0, 0, 1'b0);
    u_min_in = 4'd10;
    load = 1'b1;
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 4, 0, 0, 0, 1)) begin
      mismatched++;
      $display("[TB] FAIL rej_umin10: got %h, expected %h", obs1, exp_v(0, 0, 4, 0, 0, 0, 1));
    end
    set_load(10, 0, 0, 1'b0);
    z_sec_in = 3'd6;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(0, 0, 5, 0, 0, 0, 1)) begin
      mismatched++;
      $display("[TB] FAIL rej_zsec6: got %h, expected %h", obs1, exp_v(0, 0, 5, 0, 0, 0, 1));
    end
    step();
    compared++;
    if (obs1 !== exp_v(0, 0, 6, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL rej_resume: got %h, expected %h", obs1, exp_v(0, 0, 6, 0, 0, 0, 0));
    end
  endtask

  task automatic test_12h();
    mode_12h = 1'b1;
    set_load(11, 59, 59, 1'b1);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(11, 59, 59, 1, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL h12_1159pm: got %h, expected %h", obs1, exp_v(11, 59, 59, 1, 0, 0, 0));
    end
    step();
    compared++;
    if (obs1 !== exp_v(12, 0, 0, 0, 1, 1, 0)) begin
      mismatched++;
      $display("[TB] FAIL h12_midnight: got %h, expected %h", obs1, exp_v(12, 0, 0, 0, 1, 1, 0));
    end
    set_load(12, 59, 59, 1'b1);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(12, 59, 59, 1, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL h12_1259pm: got %h, expected %h", obs1, exp_v(12, 59, 59, 1, 0, 0, 0));
    end
    step();
    compared++;
    if (obs1 !== exp_v(1, 0, 0, 1, 1, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL h12_1pm: got %h, expected %h", obs1, exp_v(1, 0, 0, 1, 1, 0, 0));
    end
    set_load(0, 0, 0, 1'b0);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(1, 0, 1, 1, 0, 0, 1)) begin
      mismatched++;
      $display("[TB] FAIL h12_rej00: got %h, expected %h", obs1, exp_v(1, 0, 1, 1, 0, 0, 1));
    end
    mode_12h = 1'b0;
    #1;
    compared++;
    if (obs1 !== exp_v(13, 0, 1, 0, 0, 0, 1)) begin
      mismatched++;
      $display("[TB] FAIL h12_to_24: got %h, expected %h", obs1, exp_v(13, 0, 1, 0, 0, 0, 1));
    end
    mode_12h = 1'b1;
    set_load(8, 30, 0, 1'b1);
    load = 1'b1;
    step();
    load = 1'b0;
    compared++;
    if (obs1 !== exp_v(8, 30, 0, 1, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL h12_8pm: got %h, expected %h", obs1, exp_v(8, 30, 0, 1, 0, 0, 0));
    end
    mode_12h = 1'b0;
    #1;
    compared++;
    if (obs1 !== exp_v(20, 30, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL h24_20: got %h, expected %h", obs1, exp_v(20, 30, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    set_load(13, 45, 10, 1'b0);
    load = 1'b1;
    step();
    compared++;
    if (obs1 !== exp_v(13, 45, 10, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL mid_load: got %h, expected %h", obs1, exp_v(13, 45, 10, 0, 0, 0, 0));
    end
    set_load(24, 0, 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    compared++;
    if (obs1 !== exp_v(0, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL mid_rst_load: got %h, expected %h", obs1, exp_v(0, 0, 0, 0, 0, 0, 0));
    end
    mode_12h = 1'b1;
    #1;
    compared++;
    if (obs1 !== exp_v(12, 0, 0, 0, 0, 0, 0)) begin
      mismatched++;
      $display("[TB] FAIL mid_12h: got %h, expected %h", obs1, exp_v(12, 0, 0, 0, 0, 0, 0));
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_prescaler();
    int ss_exp;
    rst = 1'b1; en = 1'b1; load = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      compared++;
      if (obs4 !== exp_v(0, 0, i / 4, 0, 0, 0, 0)) begin
        mismatched++;
        $display("[TB] FAIL div4_%0d: got %h, expected %h", i, obs4, exp_v(0, 0, i / 4, 0, 0, 0, 0));
      end
    end
    // prescaler now 0; one enabled edge, three held, then three more to the tick
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      ss_exp = (i == 3) ? 3 : 2;
      compared++;
      if (obs4 !== exp_v(0, 0, ss_exp, 0, 0, 0, 0)) begin
        mismatched++;
        $display("[TB] FAIL div4_en_%0d: got %h, expected %h", i, obs4,
                 exp_v(0, 0, ss_exp, 0, 0, 0, 0));
      end
    end
    for (int i = 0; i < 3; i++) step();
    set_load(0, 0, 30, 1'b0);
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      ss_exp = (i == 4) ? 31 : 30;
      compared++;
      if (obs4 !== exp_v(0, 0, ss_exp, 0, 0, 0, 0)) begin
        mismatched++;
        $display("[TB] FAIL div4_load_%0d: got %h, expected %h", i, obs4,
                 exp_v(0, 0, ss_exp, 0, 0, 0, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_day_wrap();
    test_rejected();
    test_12h();
    test_reset_mid();
    test_prescaler();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
